// File: rtl/swap_pkg.sv
// Shared types and defaults for the swap_pair_pipe pair-exchange stage.
//   mode_e  : exchange mode carried with each pair
//   pair_t  : operand pair {a, b} at the default operand width
//   WIDTH_DEF / CNT_W_DEF : default operand and exchange-counter widths
package swap_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,   // emit unchanged
      MODE_SWAP = 2'b01,   // always exchange
      MODE_ASC  = 2'b10,   // order so that a <= b
      MODE_DESC = 2'b11    // order so that a >= b
   } mode_e;

   typedef struct packed {
      logic [WIDTH_DEF-1:0] a;
      logic [WIDTH_DEF-1:0] b;
   } pair_t;

endpackage

// File: rtl/cmp_exchange.sv
// Combinational compare-and-exchange for one operand pair.
//   a_i, b_i   : operands (unsigned)
//   mode_i     : exchange mode
//   a_o, b_o   : operands after the optional exchange
//   swapped_o  : 1 when the operands were exchanged
module cmp_exchange
   import swap_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  mode_e            mode_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             swapped_o
);

   logic do_swap;

   // Equal operands never count as an exchange in the ordering modes,
   // hence the strict comparisons.
   always_comb begin
      do_swap = 1'b0;
      case (mode_i)
         MODE_PASS: do_swap = 1'b0;
         MODE_SWAP: do_swap = 1'b1;
         MODE_ASC:  do_swap = (a_i > b_i);
         MODE_DESC: do_swap = (a_i < b_i);
         default:   do_swap = 1'b0;
      endcase
   end

   assign a_o       = do_swap ? b_i : a_i;
   assign b_o       = do_swap ? a_i : b_i;
   assign swapped_o = do_swap;

endmodule

// File: rtl/swap_pair_pipe.sv
// Two-stage valid/ready pair-exchange pipeline.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : upstream handshake; in_ready is combinational from out_ready
//   in_a, in_b, in_mode : operand pair and its exchange mode
//   out_valid/out_ready : downstream handshake
//   out_a, out_b        : exchanged pair, driven from stage S2
//   out_swapped         : 1 when the emitted pair was exchanged
//   swap_count          : saturating count of exchanged pairs transferred out
//   clear_count         : synchronous clear of swap_count, wins over an increment
module swap_pair_pipe
   import swap_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_swapped,
   output logic [CNT_W-1:0] swap_count,
   input  logic             clear_count
);

   typedef struct packed {
      logic             valid;
      mode_e            mode;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic             swapped;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } s2_t;

   s1_t              s1_q, s1_d;
   s2_t              s2_q, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             adv;
   logic [WIDTH-1:0] x_a, x_b;
   logic             x_swapped;

   // One global advance: the whole pipe moves or the whole pipe holds.
   // Without a skid buffer, in_ready has to follow out_ready combinationally.
   assign adv      = !s2_q.valid || out_ready;
   assign in_ready = adv;

   cmp_exchange #(.WIDTH(WIDTH)) u_cmp_exchange (
      .a_i       (s1_q.a),
      .b_i       (s1_q.b),
      .mode_i    (s1_q.mode),
      .a_o       (x_a),
      .b_o       (x_b),
      .swapped_o (x_swapped)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through
      // the block leaves it unassigned and no latch is inferred.
      s1_d = s1_q;
      s2_d = s2_q;
      if (adv) begin
         // Bubbles propagate too; data is only captured with a real pair,
         // which also pins the mode to the pair it arrived with.
         s1_d.valid = in_valid;
         if (in_valid) begin
            s1_d.a    = in_a;
            s1_d.b    = in_b;
            s1_d.mode = mode_e'(in_mode);
         end
         s2_d.valid   = s1_q.valid;
         s2_d.a       = x_a;
         s2_d.b       = x_b;
         s2_d.swapped = x_swapped;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear_count) begin
         cnt_d = '0;
      end else if (s2_q.valid && out_ready && s2_q.swapped && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q  <= '0;
         s2_q  <= '0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_valid   = s2_q.valid;
   assign out_a       = s2_q.a;
   assign out_b       = s2_q.b;
   assign out_swapped = s2_q.swapped;
   assign swap_count  = cnt_q;

endmodule

// File: tb/tb_swap_pair_pipe.sv
// Directed self-checking bench for swap_pair_pipe. Two instances share all
// inputs: the default-width counter and a 4-bit counter for saturation.
module tb_swap_pair_pipe;
   import swap_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_a, in_b;
   logic [1:0]  in_mode;
   logic        out_ready;
   logic        clear_count;

   logic        in_ready,  out_valid,  out_swapped;
   logic [7:0]  out_a,  out_b;
   logic [15:0] swap_count;

   logic        in_ready4, out_valid4, out_swapped4;
   logic [7:0]  out_a4, out_b4;
   logic [3:0]  swap_count4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   swap_pair_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_swapped(out_swapped), .swap_count(swap_count), .clear_count(clear_count)
   );

   swap_pair_pipe #(.WIDTH(8), .CNT_W(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid4),
      .out_ready(out_ready), .out_a(out_a4), .out_b(out_b4),
      .out_swapped(out_swapped4), .swap_count(swap_count4), .clear_count(clear_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input pair_t p, input mode_e m);
      in_valid = v;
      in_a     = p.a;
      in_b     = p.b;
      in_mode  = m;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [7:0] a,
                             input logic [7:0] b, input logic s);
      check({tag, ".valid"},  out_valid,  v);
      check({tag, ".valid4"}, out_valid4, v);
      if (v) begin
         check({tag, ".a"},  out_a,        a);
         check({tag, ".b"},  out_b,        b);
         check({tag, ".s"},  out_swapped,  s);
         check({tag, ".a4"}, out_a4,       a);
         check({tag, ".b4"}, out_b4,       b);
         check({tag, ".s4"}, out_swapped4, s);
      end
   endtask

   task automatic expect_cnt(input string tag, input logic [15:0] c16, input logic [3:0] c4);
      check({tag, ".cnt16"}, swap_count,  c16);
      check({tag, ".cnt4"},  swap_count4, c4);
   endtask

   initial begin
      rst_n       = 1'b0;
      out_ready   = 1'b1;
      clear_count = 1'b0;
      drive(1'b0, '{a: 8'd0, b: 8'd0}, MODE_PASS);
      step();
      step();
      rst_n = 1'b1;

      // 1. reset state, then a single swapped pair with 2-cycle latency
      expect_out("rst", 1'b0, 8'd0, 8'd0, 1'b0);
      check("rst.a", out_a, 8'd0);
      check("rst.b", out_b, 8'd0);
      check("rst.s", out_swapped, 1'b0);
      check("rst.in_ready", in_ready, 1'b1);
      expect_cnt("rst", 16'd0, 4'd0);
      drive(1'b1, '{a: 8'd5, b: 8'd6}, MODE_SWAP);
      step();
      in_valid = 1'b0;
      expect_out("t1.lat1", 1'b0, 8'd0, 8'd0, 1'b0);
      step();
      expect_out("t1.out", 1'b1, 8'd6, 8'd5, 1'b1);
      expect_cnt("t1.pre", 16'd0, 4'd0);
      step();
      expect_out("t1.drain", 1'b0, 8'd0, 8'd0, 1'b0);
      expect_cnt("t1.post", 16'd1, 4'd1);

      // 2. ascending mode, back-to-back, including equal operands
      drive(1'b1, '{a: 8'd9, b: 8'd3}, MODE_ASC);
      step();
      drive(1'b1, '{a: 8'd3, b: 8'd9}, MODE_ASC);
      step();
      expect_out("t2.p1", 1'b1, 8'd3, 8'd9, 1'b1);
      drive(1'b1, '{a: 8'd7, b: 8'd7}, MODE_ASC);
      step();
      expect_out("t2.p2", 1'b1, 8'd3, 8'd9, 1'b0);
      expect_cnt("t2.mid", 16'd2, 4'd2);
      in_valid = 1'b0;
      step();
      expect_out("t2.p3", 1'b1, 8'd7, 8'd7, 1'b0);
      step();
      expect_out("t2.drain", 1'b0, 8'd0, 8'd0, 1'b0);
      expect_cnt("t2.post", 16'd2, 4'd2);

      // 3. backpressure with two pairs in flight and a third waiting
      drive(1'b1, '{a: 8'd1, b: 8'd2}, MODE_SWAP);
      step();
      drive(1'b1, '{a: 8'd4, b: 8'd3}, MODE_ASC);
      step();
      drive(1'b1, '{a: 8'd10, b: 8'd20}, MODE_PASS);
      out_ready = 1'b0;
      #1;
      check("t3.in_ready_stall", in_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out("t3.hold", 1'b1, 8'd2, 8'd1, 1'b1);
         check("t3.in_ready_hold", in_ready, 1'b0);
      end
      expect_cnt("t3.hold", 16'd2, 4'd2);
      out_ready = 1'b1;
      #1;
      check("t3.in_ready_rel", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      expect_out("t3.pB", 1'b1, 8'd3, 8'd4, 1'b1);
      expect_cnt("t3.pB", 16'd3, 4'd3);
      step();
      expect_out("t3.pC", 1'b1, 8'd10, 8'd20, 1'b0);
      expect_cnt("t3.pC", 16'd4, 4'd4);
      step();
      expect_out("t3.drain", 1'b0, 8'd0, 8'd0, 1'b0);

      // 4. reset with two pairs in flight drops them
      drive(1'b1, '{a: 8'd11, b: 8'd12}, MODE_SWAP);
      step();
      drive(1'b1, '{a: 8'd13, b: 8'd14}, MODE_SWAP);
      step();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n = 1'b1;
      expect_out("t4.rst", 1'b0, 8'd0, 8'd0, 1'b0);
      check("t4.a", out_a, 8'd0);
      check("t4.b", out_b, 8'd0);
      check("t4.s", out_swapped, 1'b0);
      expect_cnt("t4.rst", 16'd0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("t4.gone", 1'b0, 8'd0, 8'd0, 1'b0);
      end

      // 5. 17 swapped pairs: 4-bit counter saturates at 15; clear beats increment
      drive(1'b1, '{a: 8'd1, b: 8'd2}, MODE_SWAP);
      for (int i = 0; i < 17; i++) step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      expect_out("t5.drain", 1'b0, 8'd0, 8'd0, 1'b0);
      expect_cnt("t5.sat", 16'd17, 4'd15);
      drive(1'b1, '{a: 8'd1, b: 8'd2}, MODE_SWAP);
      step();
      in_valid = 1'b0;
      step();
      expect_out("t5.clr_pair", 1'b1, 8'd2, 8'd1, 1'b1);
      clear_count = 1'b1;
      step();
      clear_count = 1'b0;
      expect_cnt("t5.clr", 16'd0, 4'd0);
      expect_out("t5.clr_drain", 1'b0, 8'd0, 8'd0, 1'b0);

      // 6. mode travels with its pair
      drive(1'b1, '{a: 8'd2, b: 8'd8}, MODE_DESC);
      step();
      drive(1'b1, '{a: 8'd2, b: 8'd8}, MODE_PASS);
      step();
      expect_out("t6.p1", 1'b1, 8'd8, 8'd2, 1'b1);
      drive(1'b0, '{a: 8'd0, b: 8'd0}, MODE_SWAP);
      step();
      expect_out("t6.p2", 1'b1, 8'd2, 8'd8, 1'b0);
      expect_cnt("t6.p2", 16'd1, 4'd1);
      step();
      expect_out("t6.drain", 1'b0, 8'd0, 8'd0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
